conversor_bcd_saida: RTL and testbench

- Sequential binary-to-BCD converter sitting between the datapath register-read value and the four 7-segment decoders. Replaces the combinational digit split.
- On an `out` instruction pulse it captures the 32-bit register value (two's complement). It then runs an iterative double-dabble over 14 magnitude bits and presents four registered BCD digits plus sign and overflow flags.
- Held outputs keep the display stable between `out` instructions.

---
 rtl/conversor_bcd_saida.sv | 164 ++++++++++++++++
 tb/tb_conversor_bcd_saida.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/conversor_bcd_saida.sv
// Sequential binary-to-BCD converter for the 4-digit 7-segment display.
// Captures a two's-complement value on inicia and holds sign/overflow-flagged BCD digits.
module conversor_bcd_saida #(
    parameter int DATA_WIDTH = 32,
    parameter int MAG_BITS   = 14
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  inicia,
    input  logic [DATA_WIDTH-1:0] entrada_modulo,
    output logic [3:0]            dp1,
    output logic [3:0]            dp2,
    output logic [3:0]            dp3,
    output logic [3:0]            dp4,
    output logic                  sinal_neg,
    output logic                  estouro,
    output logic                  valido,
    output logic                  ocupado
);

    localparam int SR_W = 16 + MAG_BITS;

    typedef enum logic [1:0] {OCIOSO, CARGA, DESLOCA, FIM} estado_t;

    estado_t               estado_q, estado_d;
    logic [DATA_WIDTH-1:0] captura_q, captura_d;
    logic [DATA_WIDTH-1:0] mag;
    logic                  neg_q, neg_d;
    logic                  ovf_q, ovf_d;
    logic [SR_W-1:0]       desloca_q, desloca_d;
    logic [3:0]            cont_q, cont_d;
    logic [3:0]            dp1_q, dp1_d, dp2_q, dp2_d, dp3_q, dp3_d, dp4_q, dp4_d;
    logic                  sinal_q, sinal_d;
    logic                  estouro_q, estouro_d;
    logic                  valido_q, valido_d;
    logic                  ocupado_q, ocupado_d;

    // One double-dabble iteration: correct every BCD nibble >= 5, then shift left.
    function automatic logic [SR_W-1:0] passo(input logic [SR_W-1:0] sr);
        logic [SR_W-1:0] t;
        t = sr;
        for (int i = 0; i < 4; i++) begin
            if (t[MAG_BITS+4*i +: 4] >= 4'd5)
                t[MAG_BITS+4*i +: 4] = t[MAG_BITS+4*i +: 4] + 4'd3;
        end
        return {t[SR_W-2:0], 1'b0};
    endfunction

    // -2^31 wraps to itself and is then caught by the unsigned overflow compare.
    always_comb begin
        mag = captura_q[DATA_WIDTH-1] ? -captura_q : captura_q;
    end

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        estado_d  = estado_q;
        captura_d = captura_q;
        neg_d     = neg_q;
        ovf_d     = ovf_q;
        desloca_d = desloca_q;
        cont_d    = cont_q;
        dp1_d     = dp1_q;
        dp2_d     = dp2_q;
        dp3_d     = dp3_q;
        dp4_d     = dp4_q;
        sinal_d   = sinal_q;
        estouro_d = estouro_q;
        valido_d  = 1'b0;
        ocupado_d = ocupado_q;

        unique case (estado_q)
            OCIOSO: begin
                if (inicia) begin
                    captura_d = entrada_modulo;
                    ocupado_d = 1'b1;
                    estado_d  = CARGA;
                end
            end
            CARGA: begin
                neg_d = captura_q[DATA_WIDTH-1];
                if (mag > DATA_WIDTH'(9999)) begin
                    ovf_d    = 1'b1;
                    estado_d = FIM;
                end else begin
                    ovf_d     = 1'b0;
                    desloca_d = {16'b0, mag[MAG_BITS-1:0]};
                    cont_d    = 4'd0;
                    estado_d  = DESLOCA;
                end
            end
            DESLOCA: begin
                desloca_d = passo(desloca_q);
                cont_d    = cont_q + 4'd1;
                if (cont_q == 4'(MAG_BITS - 1))
                    estado_d = FIM;
            end
            FIM: begin
                if (ovf_q) begin
                    dp4_d = 4'd9;
                    dp3_d = 4'd9;
                    dp2_d = 4'd9;
                    dp1_d = 4'd9;
                end else begin
                    dp4_d = desloca_q[MAG_BITS+12 +: 4];
                    dp3_d = desloca_q[MAG_BITS+8  +: 4];
                    dp2_d = desloca_q[MAG_BITS+4  +: 4];
                    dp1_d = desloca_q[MAG_BITS    +: 4];
                end
                sinal_d   = neg_q;
                estouro_d = ovf_q;
                valido_d  = 1'b1;
                ocupado_d = 1'b0;
                estado_d  = OCIOSO;
            end
            default: estado_d = OCIOSO;
        endcase
    end

    // NOTE: all state, including the capture register, is reset so an abort leaves nothing stale.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q  <= OCIOSO;
            captura_q <= '0;
            neg_q     <= 1'b0;
            ovf_q     <= 1'b0;
            desloca_q <= '0;
            cont_q    <= 4'd0;
            dp1_q     <= 4'd0;
            dp2_q     <= 4'd0;
            dp3_q     <= 4'd0;
            dp4_q     <= 4'd0;
            sinal_q   <= 1'b0;
            estouro_q <= 1'b0;
            valido_q  <= 1'b0;
            ocupado_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values.
            estado_q  <= estado_d;
            captura_q <= captura_d;
            neg_q     <= neg_d;
            ovf_q     <= ovf_d;
            desloca_q <= desloca_d;
            cont_q    <= cont_d;
            dp1_q     <= dp1_d;
            dp2_q     <= dp2_d;
            dp3_q     <= dp3_d;
            dp4_q     <= dp4_d;
            sinal_q   <= sinal_d;
            estouro_q <= estouro_d;
            valido_q  <= valido_d;
            ocupado_q <= ocupado_d;
        end
    end

    assign dp1       = dp1_q;
    assign dp2       = dp2_q;
    assign dp3       = dp3_q;
    assign dp4       = dp4_q;
    assign sinal_neg = sinal_q;
    assign estouro   = estouro_q;
    assign valido    = valido_q;
    assign ocupado   = ocupado_q;

endmodule

// File: tb/tb_conversor_bcd_saida.sv
// Scoreboard bench for conversor_bcd_saida: stimulus pushes expectations, a monitor
// pops and compares each valido pulse (digits, sign, overflow and arrival cycle).
module tb_conversor_bcd_saida;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        inicia = 1'b0;
    logic [31:0] entrada_modulo = '0;
    logic [3:0]  dp1, dp2, dp3, dp4;
    logic        sinal_neg, estouro, valido, ocupado;

    conversor_bcd_saida dut (
        .clock          (clock),
        .reset          (reset),
        .inicia         (inicia),
        .entrada_modulo (entrada_modulo),
        .dp1            (dp1),
        .dp2            (dp2),
        .dp3            (dp3),
        .dp4            (dp4),
        .sinal_neg      (sinal_neg),
        .estouro        (estouro),
        .valido         (valido),
        .ocupado        (ocupado)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [15:0] bcd;
        logic        neg;
        logic        ovf;
        int          cyc;
    } exp_t;

    typedef struct {
        int          v;
        logic [15:0] bcd;
        logic        neg;
        logic        ovf;
    } vec_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   compared = 0;
    int   mismatched = 0;

    always @(posedge clock) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every valido pulse must match the oldest outstanding expectation.
    always @(posedge clock) begin
        #1;
        if (reset && valido === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valido", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("digits", {16'h0, dp4, dp3, dp2, dp1}, {16'h0, e.bcd});
                check("sinal_neg", {31'b0, sinal_neg}, {31'b0, e.neg});
                check("estouro", {31'b0, estouro}, {31'b0, e.ovf});
                check("valido_cycle", cyc, e.cyc);
            end
        end
    end

    // Independent reference: decimal arithmetic on a 64-bit magnitude.
    function automatic vec_t model(input int v);
        vec_t   r;
        longint m;
        m     = (v < 0) ? -longint'(v) : longint'(v);
        r.v   = v;
        r.neg = (v < 0);
        r.ovf = (m > 9999);
        if (r.ovf) r.bcd = 16'h9999;
        else r.bcd = {4'(m / 1000), 4'((m / 100) % 10), 4'((m / 10) % 10), 4'(m % 10)};
        return r;
    endfunction

    // Drive inicia for one cycle; returns at the negedge after the sampling edge E0.
    task automatic pulse(input vec_t t);
        exp_t e;
        @(negedge clock);
        inicia         = 1'b1;
        entrada_modulo = t.v;
        e.bcd = t.bcd;
        e.neg = t.neg;
        e.ovf = t.ovf;
        e.cyc = cyc + 1 + (t.ovf ? 2 : 16);
        exp_q.push_back(e);
        @(negedge clock);
        inicia = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(negedge clock);
            n++;
        end
        if (exp_q.size() != 0) begin
            check("timeout_pending", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_digits"}, {16'h0, dp4, dp3, dp2, dp1}, 32'h0);
        check({tag, "_flags"}, {28'h0, sinal_neg, estouro, valido, ocupado}, 32'h0);
    endtask

    vec_t dir[10];
    int   sweep[$];

    initial begin
        dir[0] = '{1234,        16'h1234, 1'b0, 1'b0};
        dir[1] = '{-56,         16'h0056, 1'b1, 1'b0};
        dir[2] = '{0,           16'h0000, 1'b0, 1'b0};
        dir[3] = '{10000,       16'h9999, 1'b0, 1'b1};
        dir[4] = '{int'(32'h80000000), 16'h9999, 1'b1, 1'b1};
        dir[5] = '{9999,        16'h9999, 1'b0, 1'b0};
        dir[6] = '{-9999,       16'h9999, 1'b1, 1'b0};
        dir[7] = '{-10000,      16'h9999, 1'b1, 1'b1};
        dir[8] = '{2147483647,  16'h9999, 1'b0, 1'b1};
        dir[9] = '{-2147483647, 16'h9999, 1'b1, 1'b1};

        repeat (3) @(negedge clock);
        check_idle_outputs("reset");
        reset = 1'b1;

        // 1234 with ocupado tracked edge by edge: high after E0..E15, low after E16.
        pulse(dir[0]);
        check("ocupado_E0", {31'b0, ocupado}, 32'd1);
        for (int k = 1; k <= 16; k++) begin
            @(negedge clock);
            check($sformatf("ocupado_E%0d", k), {31'b0, ocupado}, (k < 16) ? 32'd1 : 32'd0);
        end
        wait_done();

        for (int i = 1; i < 10; i++) begin
            pulse(dir[i]);
            wait_done();
        end

        // inicia while busy is dropped; inicia in the valido cycle is accepted.
        pulse('{4321, 16'h4321, 1'b0, 1'b0});
        repeat (4) @(negedge clock);
        inicia         = 1'b1;
        entrada_modulo = 7777;
        @(negedge clock);
        inicia = 1'b0;
        wait_done();
        pulse('{7777, 16'h7777, 1'b0, 1'b0});
        wait_done();

        // Reset between edges after E8 aborts the conversion and clears outputs at once.
        pulse(dir[0]);
        repeat (8) @(negedge clock);
        reset = 1'b0;
        exp_q.delete();
        #1;
        check_idle_outputs("abort");
        repeat (2) @(negedge clock);
        reset = 1'b1;
        pulse('{42, 16'h0042, 1'b0, 1'b0});
        wait_done();

        for (int v = -9999; v <= 9999; v += 487) sweep.push_back(v);
        sweep.push_back(1);
        sweep.push_back(-1);
        sweep.push_back(99);
        sweep.push_back(-100);
        sweep.push_back(1000);
        foreach (sweep[i]) begin
            pulse(model(sweep[i]));
            wait_done();
        end

        repeat (20) @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
